// File: rtl/ebr_arb_pkg.sv
// Shared types and helpers for the EBR RAM read-port arbiter.
// Optional feature macro used by the arbiter: EBR_ARB_FIXED_PRIO_EN.
package ebr_arb_pkg;

   localparam int MAX_TAG_DEPTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } arb_state_t;

   // Requester ID width; never narrower than one bit.
   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/ebr_arb_tag_fifo.sv
// In-order FIFO of requester IDs for reads issued to the RAM but not yet returned.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ebr_arb_tag_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 2
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_push_data,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_push;
   logic              do_pop;

   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
   always_ff @(posedge i_clock) begin
      if (do_push) mem[wr_ptr] <= i_push_data;
   end

   assign o_head  = mem[rd_ptr];
   assign o_count = count;
   assign o_empty = (count == '0);
   assign o_full  = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/ebr_ram_read_arb.sv
// Round-robin arbiter sharing one EBR RAM read-address port; returned data is tagged in order.
// Define EBR_ARB_FIXED_PRIO_EN to give requester 0 strict priority over the round-robin group.
module ebr_ram_read_arb
   import ebr_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 10,
   parameter int WIDTH     = 8,
   parameter int TAG_DEPTH = 4
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic [ADDR_W-1:0]             o_ram_addr,
   output logic                          o_ram_addr_valid,
   input  logic                          i_ram_addr_ready,
   input  logic [WIDTH-1:0]              i_ram_data,
   input  logic                          i_ram_valid,
   output logic                          o_ram_ready,
   output logic [WIDTH-1:0]              o_rsp_data,
   output logic [id_width(NUM_REQ)-1:0]  o_rsp_id,
   output logic                          o_rsp_valid,
   input  logic                          i_rsp_ready,
   output logic [$clog2(TAG_DEPTH):0]    o_outstanding,
   output logic                          o_err_orphan
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

   if (TAG_DEPTH > MAX_TAG_DEPTH || TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ebr_ram_read_arb: TAG_DEPTH must be a power of two in 2..%0d", MAX_TAG_DEPTH);
   end

   arb_state_t         state;
   logic [ADDR_W-1:0]  ram_addr;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    next_ptr;
   logic               grant_found;
   logic               can_accept;
   logic               accept;
   logic               rsp_pop;
   logic               fifo_empty;
   logic               fifo_full;
   logic               err_orphan;
   logic [CNT_W-1:0]   tag_count;
   logic [NUM_REQ-1:0] req_ready;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
`ifdef EBR_ARB_FIXED_PRIO_EN
      if (i_req_valid[0]) grant_found = 1'b1;
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
`ifdef EBR_ARB_FIXED_PRIO_EN
         if (!grant_found && cand != '0 && i_req_valid[cand]) begin
`else
         if (!grant_found && i_req_valid[cand]) begin
`endif
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   assign next_ptr   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   // fifo_full comes from the registered count, so a same-cycle pop cannot unblock.
   assign can_accept = (state == IDLE || i_ram_addr_ready) && !fifo_full;
   assign accept     = can_accept && grant_found;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_id] = 1'b1;
   end

   assign rsp_pop = i_ram_valid && i_rsp_ready && !fifo_empty;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         ram_addr   <= '0;
         rr_ptr     <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (accept) begin
            state    <= PEND;
            ram_addr <= i_req_addr[grant_id*ADDR_W +: ADDR_W];
`ifdef EBR_ARB_FIXED_PRIO_EN
            if (grant_id != '0) rr_ptr <= next_ptr;
`else
            rr_ptr   <= next_ptr;
`endif
         end else if (state == PEND && i_ram_addr_ready) begin
            state <= IDLE;
         end
         if (i_ram_valid && fifo_empty) err_orphan <= 1'b1;
      end
   end

   ebr_arb_tag_fifo #(
      .DEPTH  (TAG_DEPTH),
      .DATA_W (ID_W)
   ) u_tag_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (accept),
      .i_push_data (grant_id),
      .i_pop       (rsp_pop),
      .o_head      (o_rsp_id),
      .o_count     (tag_count),
      .o_empty     (fifo_empty),
      .o_full      (fifo_full)
   );

   assign o_req_ready      = req_ready;
   assign o_ram_addr       = ram_addr;
   assign o_ram_addr_valid = (state == PEND);
   assign o_ram_ready      = i_rsp_ready;
   assign o_rsp_data       = i_ram_data;
   assign o_rsp_valid      = i_ram_valid;
   assign o_outstanding    = tag_count;
   assign o_err_orphan     = err_orphan;

endmodule

// File: tb/tb_ebr_ram_read_arb.sv
// Self-checking bench for ebr_ram_read_arb: grant table, scoreboarded responses, stall/full/orphan/reset sequences.
module tb_ebr_ram_read_arb;

   localparam int NUM_REQ   = 4;
   localparam int ADDR_W    = 10;
   localparam int WIDTH     = 8;
   localparam int TAG_DEPTH = 4;
   localparam int ID_W      = 2;
   localparam int CNT_W     = 3;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
   } exp_t;

   typedef struct {
      logic [NUM_REQ-1:0] valid;
      logic [NUM_REQ-1:0] ready;
   } vec_t;

   logic                      i_clock = 1'b0;
   logic                      i_reset;
   logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic [ADDR_W-1:0]         o_ram_addr;
   logic                      o_ram_addr_valid;
   logic                      i_ram_addr_ready;
   logic [WIDTH-1:0]          i_ram_data;
   logic                      i_ram_valid;
   logic                      o_ram_ready;
   logic [WIDTH-1:0]          o_rsp_data;
   logic [ID_W-1:0]           o_rsp_id;
   logic                      o_rsp_valid;
   logic                      i_rsp_ready;
   logic [CNT_W-1:0]          o_outstanding;
   logic                      o_err_orphan;

   exp_t              exp_q[$];
   logic [ADDR_W-1:0] ram_pipe[$];
   exp_t              mon_e;
   exp_t              mon_got;
   logic [ADDR_W-1:0] rsp_a;
   bit                auto_ram;
   bit                sb_en;
   bit                ram_taken;
   int                n_cmp;
   int                n_bad;
   vec_t              vecs[13];
   logic [NUM_REQ-1:0] exp_g;

   ebr_ram_read_arb #(
      .NUM_REQ   (NUM_REQ),
      .ADDR_W    (ADDR_W),
      .WIDTH     (WIDTH),
      .TAG_DEPTH (TAG_DEPTH)
   ) dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_req_addr       (i_req_addr),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .o_ram_addr       (o_ram_addr),
      .o_ram_addr_valid (o_ram_addr_valid),
      .i_ram_addr_ready (i_ram_addr_ready),
      .i_ram_data       (i_ram_data),
      .i_ram_valid      (i_ram_valid),
      .o_ram_ready      (o_ram_ready),
      .o_rsp_data       (o_rsp_data),
      .o_rsp_id         (o_rsp_id),
      .o_rsp_valid      (o_rsp_valid),
      .i_rsp_ready      (i_rsp_ready),
      .o_outstanding    (o_outstanding),
      .o_err_orphan     (o_err_orphan)
   );

   always #5 i_clock = ~i_clock;

   // RAM contents seen by both the responder and the scoreboard.
   function automatic logic [WIDTH-1:0] ram_word(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ {2'b10, a[9:8], 2'b01, a[9:8]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_addr(input int k, input logic [ADDR_W-1:0] a);
      i_req_addr[k*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic step_to_pos();
      @(posedge i_clock);
      #1;
   endtask

   task automatic do_reset();
      auto_ram         = 1'b0;
      sb_en            = 1'b0;
      i_reset          = 1'b1;
      i_req_valid      = '0;
      i_req_addr       = '0;
      i_ram_valid      = 1'b0;
      i_ram_data       = '0;
      i_ram_addr_ready = 1'b1;
      i_rsp_ready      = 1'b1;
      exp_q.delete();
      ram_pipe.delete();
      ram_taken        = 1'b0;
      repeat (2) @(posedge i_clock);
      #1 i_reset = 1'b0;
   endtask

   // Monitor: sampled on the falling edge, records handshakes that complete at the next rising edge.
   always @(negedge i_clock) begin
      ram_taken = i_ram_valid && o_ram_ready;
      if (!i_reset) begin
         check("req_ready_onehot", ($countones(o_req_ready) <= 1), 1);
         if (o_ram_addr_valid && i_ram_addr_ready) ram_pipe.push_back(o_ram_addr);
         for (int k = 0; k < NUM_REQ; k++) begin
            if (o_req_ready[k]) begin
               check("grant_needs_valid", i_req_valid[k], 1);
               if (sb_en) begin
                  mon_e.id   = ID_W'(k);
                  mon_e.data = ram_word(i_req_addr[k*ADDR_W +: ADDR_W]);
                  exp_q.push_back(mon_e);
               end
            end
         end
         if (sb_en && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               mon_got = exp_q.pop_front();
               check("rsp_id", o_rsp_id, mon_got.id);
               check("rsp_data", o_rsp_data, mon_got.data);
            end
         end
      end
   end

   // RAM responder: one-cycle read latency, holds a beat until it is taken.
   always @(posedge i_clock) begin
      #2;
      if (auto_ram) begin
         if (ram_taken || !i_ram_valid) begin
            if (ram_pipe.size() > 0) begin
               rsp_a       = ram_pipe.pop_front();
               i_ram_data  = ram_word(rsp_a);
               i_ram_valid = 1'b1;
            end else begin
               i_ram_valid = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;

`ifdef EBR_ARB_FIXED_PRIO_EN
      vecs = '{
         '{4'b1111, 4'b0001}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0001},
         '{4'b1111, 4'b0001}, '{4'b1111, 4'b0001}, '{4'b0001, 4'b0001},
         '{4'b1000, 4'b1000}, '{4'b0110, 4'b0010}, '{4'b0110, 4'b0100},
         '{4'b0000, 4'b0000}, '{4'b0101, 4'b0001}, '{4'b0101, 4'b0001},
         '{4'b1001, 4'b0001}};
`else
      vecs = '{
         '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
         '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b0001, 4'b0001},
         '{4'b1000, 4'b1000}, '{4'b0110, 4'b0010}, '{4'b0110, 4'b0100},
         '{4'b0000, 4'b0000}, '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100},
         '{4'b1001, 4'b1000}};
`endif

      // Reset state
      do_reset();
      @(negedge i_clock);
      check("rst_addr_valid", o_ram_addr_valid, 0);
      check("rst_addr", o_ram_addr, 0);
      check("rst_outstanding", o_outstanding, 0);
      check("rst_orphan", o_err_orphan, 0);
      check("rst_req_ready", o_req_ready, 0);
      check("rst_rsp_valid", o_rsp_valid, 0);
      step_to_pos();

      // Grant-order table with scoreboarded responses
      auto_ram = 1'b1;
      sb_en    = 1'b1;
      foreach (vecs[i]) begin
         for (int k = 0; k < NUM_REQ; k++) set_addr(k, ADDR_W'((i * 37 + k * 101 + 5) % 1024));
         i_req_valid = vecs[i].valid;
         @(negedge i_clock);
         check($sformatf("table_grant[%0d]", i), o_req_ready, vecs[i].ready);
         step_to_pos();
      end
      i_req_valid = '0;
      repeat (6) step_to_pos();
      @(negedge i_clock);
      check("table_drained_outstanding", o_outstanding, 0);
      check("table_drained_sb", exp_q.size(), 0);

      // Address stall: requester 2 alone, RAM address ready low for 3 cycles
      do_reset();
      auto_ram = 1'b1;
      sb_en    = 1'b1;
      set_addr(2, 10'h155);
      i_req_valid      = 4'b0100;
      i_ram_addr_ready = 1'b0;
      @(negedge i_clock);
      check("stall_grant", o_req_ready, 4'b0100);
      step_to_pos();
      i_req_valid = '0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) i_ram_addr_ready = 1'b1;
         @(negedge i_clock);
         check($sformatf("stall_addr[%0d]", c), o_ram_addr, 10'h155);
         check($sformatf("stall_valid[%0d]", c), o_ram_addr_valid, 1);
         check($sformatf("stall_outstanding[%0d]", c), o_outstanding, 1);
         step_to_pos();
      end
      @(negedge i_clock);
      check("stall_valid_drop", o_ram_addr_valid, 0);
      check("stall_outstanding_before_rsp", o_outstanding, 1);
      check("stall_rsp_valid", o_rsp_valid, 1);
      step_to_pos();
      @(negedge i_clock);
      check("stall_outstanding_after_rsp", o_outstanding, 0);
      check("stall_sb_empty", exp_q.size(), 0);
      step_to_pos();

      // Tag FIFO full: response ready held low with continuous requests
      do_reset();
      auto_ram    = 1'b1;
      sb_en       = 1'b1;
      i_rsp_ready = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) set_addr(k, ADDR_W'(16 * k + 3));
      i_req_valid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
`ifdef EBR_ARB_FIXED_PRIO_EN
         exp_g = 4'b0001;
`else
         exp_g = NUM_REQ'(1 << g);
`endif
         @(negedge i_clock);
         check($sformatf("full_grant[%0d]", g), o_req_ready, exp_g);
         step_to_pos();
      end
      @(negedge i_clock);
      check("full_outstanding", o_outstanding, 4);
      check("full_no_grant", o_req_ready, 0);
      step_to_pos();
      i_rsp_ready = 1'b1;
      @(negedge i_clock);
      check("full_pop_cycle_no_grant", o_req_ready, 0);
      check("full_pop_cycle_outstanding", o_outstanding, 4);
      step_to_pos();
      @(negedge i_clock);
      check("full_after_pop_outstanding", o_outstanding, 3);
      check("full_after_pop_grant", o_req_ready, 4'b0001);
      step_to_pos();
      i_req_valid = '0;
      repeat (12) step_to_pos();
      @(negedge i_clock);
      check("full_drained_outstanding", o_outstanding, 0);
      check("full_drained_sb", exp_q.size(), 0);
      step_to_pos();

      // Orphan response with nothing issued
      do_reset();
      i_ram_valid = 1'b1;
      i_ram_data  = 8'h3C;
      @(negedge i_clock);
      check("orphan_before_edge", o_err_orphan, 0);
      check("orphan_passthru_valid", o_rsp_valid, 1);
      check("orphan_passthru_data", o_rsp_data, 8'h3C);
      step_to_pos();
      i_ram_valid = 1'b0;
      @(negedge i_clock);
      check("orphan_set", o_err_orphan, 1);
      check("orphan_no_underflow", o_outstanding, 0);
      repeat (3) step_to_pos();
      @(negedge i_clock);
      check("orphan_sticky", o_err_orphan, 1);
      step_to_pos();

`ifdef EBR_ARB_FIXED_PRIO_EN
      // Requester 0 strict priority over requester 3
      do_reset();
      auto_ram = 1'b1;
      sb_en    = 1'b1;
      set_addr(0, 10'h011);
      set_addr(3, 10'h2F3);
      i_req_valid = 4'b1001;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clock);
         check($sformatf("prio_grant0[%0d]", c), o_req_ready, 4'b0001);
         step_to_pos();
      end
      i_req_valid = 4'b1000;
      @(negedge i_clock);
      check("prio_grant3", o_req_ready, 4'b1000);
      step_to_pos();
      i_req_valid = '0;
      repeat (8) step_to_pos();
      @(negedge i_clock);
      check("prio_drained_sb", exp_q.size(), 0);
      step_to_pos();
`endif

      // Asynchronous reset mid-burst with 3 reads outstanding
      do_reset();
      auto_ram    = 1'b1;
      sb_en       = 1'b1;
      i_rsp_ready = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) set_addr(k, ADDR_W'(200 + k));
      i_req_valid = 4'b1111;
      repeat (3) step_to_pos();
      #1;
      check("midrst_outstanding_before", o_outstanding, 3);
      #1 i_reset = 1'b1;
      #1;
      check("midrst_outstanding", o_outstanding, 0);
      check("midrst_addr_valid", o_ram_addr_valid, 0);
      check("midrst_addr", o_ram_addr, 0);
      check("midrst_orphan", o_err_orphan, 0);
      auto_ram = 1'b0;
      sb_en    = 1'b0;
      exp_q.delete();
      ram_pipe.delete();
      i_ram_valid = 1'b1;
      i_ram_data  = 8'hE7;
      i_rsp_ready = 1'b1;
      step_to_pos();
      i_reset = 1'b0;
      @(negedge i_clock);
      check("midrst_next_grant", o_req_ready, 4'b0001);
      check("midrst_orphan_pending", o_err_orphan, 0);
      step_to_pos();
      i_ram_valid = 1'b0;
      i_req_valid = '0;
      @(negedge i_clock);
      check("midrst_late_rsp_orphan", o_err_orphan, 1);
      check("midrst_outstanding_after", o_outstanding, 1);
      step_to_pos();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
